// File: rtl/board_pkg.sv
// Shared definitions for the board self-test: mode encoding, seven-segment table, defaults.
package board_pkg;

  localparam int unsigned DEF_NPB        = 20;
  localparam int unsigned DEF_DB_CYCLES  = 4;
  localparam int unsigned DEF_SCROLL_DIV = 25;

  typedef enum logic [1:0] {
    ModePass  = 2'd0,
    ModeWalk  = 2'd1,
    ModeCount = 2'd2
  } mode_e;

  // Segment patterns {dp,g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to seven-segment decoder.
module hex7seg
  import board_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/board_selftest.sv
// Board self-test: debounced pushbuttons drive LEDs/segments in PASS, WALK and COUNT modes.
module board_selftest
  import board_pkg::*;
#(
  parameter int unsigned NPB        = DEF_NPB,
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned SCROLL_DIV = DEF_SCROLL_DIV
) (
  input  logic           hz100,
  input  logic           reset,
  input  logic [NPB-1:0] PB,
  output logic [7:0]     RIGHT,
  output logic [7:0]     LEFT,
  output logic           RED,
  output logic           GREEN,
  output logic           BLUE,
  output logic [7:0]     SS0,
  output logic [7:0]     SS1,
  output logic [7:0]     SS2,
  output logic [7:0]     SS3,
  output logic [7:0]     SS4,
  output logic [7:0]     SS5,
  output logic [7:0]     SS6,
  output logic [7:0]     SS7
);

  logic [NPB-1:0] r_sync1, r_sync2, r_db, r_db_prev;
  logic [7:0]     r_db_cnt [NPB];

  always_ff @(posedge hz100) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < NPB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= PB;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
      for (int i = 0; i < NPB; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == 8'(DB_CYCLES - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  logic [NPB-1:0] w_rise;
  logic           w_mode_adv, w_cnt_rise;
  assign w_rise     = r_db & ~r_db_prev;
  assign w_mode_adv = w_rise[NPB-1];
  assign w_cnt_rise = |w_rise[NPB-2:0];

  mode_e       r_mode;
  logic [15:0] r_ring, r_tick, r_count;
  logic [2:0]  r_seg;

  always_ff @(posedge hz100) begin
    if (reset) begin
      r_mode  <= ModePass;
      r_ring  <= '0;
      r_tick  <= '0;
      r_seg   <= '0;
      r_count <= '0;
    end else if (w_mode_adv) begin
      // Mode change takes priority over any simultaneous count rise.
      case (r_mode)
        ModePass: begin
          r_mode <= ModeWalk;
          r_ring <= 16'h0001;
          r_tick <= '0;
          r_seg  <= '0;
        end
        ModeWalk: begin
          r_mode  <= ModeCount;
          r_count <= '0;
        end
        default: r_mode <= ModePass;
      endcase
    end else begin
      if (r_mode == ModeWalk) begin
        if (r_tick == 16'(SCROLL_DIV - 1)) begin
          r_tick <= '0;
          r_ring <= {r_ring[14:0], r_ring[15]};
          r_seg  <= r_seg + 3'd1;
        end else begin
          r_tick <= r_tick + 16'd1;
        end
      end
      if (r_mode == ModeCount && w_cnt_rise) r_count <= r_count + 16'd1;
    end
  end

  logic [7:0] w_hex [4];
  for (genvar g = 0; g < 4; g++) begin : g_hex
    hex7seg u_hex (
      .i_nib(r_count[4*g +: 4]),
      .o_seg(w_hex[g])
    );
  end

  logic [7:0] w_right, w_left;
  logic [2:0] w_rgb;
  logic [7:0] w_ss [8];

  always_comb begin
    w_right = '0;
    w_left  = '0;
    w_rgb   = '0;
    for (int k = 0; k < 8; k++) w_ss[k] = '0;
    case (r_mode)
      ModePass: begin
        w_right = r_db[7:0];
        w_left  = r_db[15:8];
        w_rgb   = r_db[18:16];
        for (int k = 0; k < 4; k++) w_ss[k] = r_db[k +: 8];
        for (int k = 4; k < 8; k++) w_ss[k] = r_db[k+5 +: 8];
      end
      ModeWalk: begin
        {w_left, w_right} = r_ring;
        w_rgb             = 3'b010;
        for (int k = 0; k < 8; k++) w_ss[k] = 8'd1 << r_seg;
      end
      default: begin
        {w_left, w_right} = r_count;
        w_rgb             = 3'b001;
        for (int k = 0; k < 4; k++) w_ss[k] = w_hex[k];
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      RIGHT <= '0;
      LEFT  <= '0;
      {RED, GREEN, BLUE} <= '0;
      {SS7, SS6, SS5, SS4, SS3, SS2, SS1, SS0} <= '0;
    end else begin
      RIGHT <= w_right;
      LEFT  <= w_left;
      {RED, GREEN, BLUE} <= w_rgb;
      {SS7, SS6, SS5, SS4, SS3, SS2, SS1, SS0} <=
          {w_ss[7], w_ss[6], w_ss[5], w_ss[4], w_ss[3], w_ss[2], w_ss[1], w_ss[0]};
    end
  end

endmodule
